// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen
//   Step/direction pulse generator. A start strobe latches a step count,
//   period and direction; after a direction setup delay the block emits
//   step_num pulses of PULSE_WIDTH cycles, one per period, then pulses done.
//   stop aborts the move in SETUP or RUN.
//
//   Optional feature: define STEP_RAMP_EN for linear acceleration. The first
//   period is four times the effective period (saturating), and each later
//   period shrinks by RAMP_DEC down to the effective period.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   one-cycle command strobe, sampled only in IDLE
//   stop      in   abort request, honoured in SETUP and RUN
//   dir_in    in   requested direction, latched on start
//   step_num  in   [31:0] number of steps, latched on start
//   period    in   [31:0] step period in cycles, latched on start
//   busy      out  move in progress (SETUP or RUN)
//   done      out  one-cycle completion/abort pulse
//   step_out  out  step pulse to the driver
//   dir_out   out  direction to the driver, held between moves
//   step_cnt  out  [31:0] completed step periods of current/last move
module stepper_pulse_gen #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned PULSE_WIDTH = 100,
  parameter int unsigned DIR_SETUP   = 50,
  parameter int unsigned MIN_PERIOD  = 200,
  parameter int unsigned RAMP_DEC    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dir_in,
  input  logic [31:0] step_num,
  input  logic [31:0] period,
  output logic        busy,
  output logic        done,
  output logic        step_out,
  output logic        dir_out,
  output logic [31:0] step_cnt
);

  if (CLK_FREQ == 0 || DIR_SETUP == 0 || MIN_PERIOD <= PULSE_WIDTH || RAMP_DEC == 0) begin : g_param_err
    $error("stepper_pulse_gen: invalid parameter set");
  end

  localparam logic [31:0] PW_W       = 32'(PULSE_WIDTH);
  localparam logic [31:0] MIN_P_W    = 32'(MIN_PERIOD);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RUN,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_step_num;
  logic [31:0] r_eff_period;
  logic [31:0] r_cnt;        // setup delay counter in SETUP, period_cnt in RUN
  logic [31:0] r_step_cnt;
  logic        r_dir;
  logic [31:0] w_eff_in;
  logic [31:0] w_cur_period;
  logic        w_period_end;
  logic        w_last_step;

  assign w_eff_in = (period < MIN_P_W) ? MIN_P_W : period;

`ifdef STEP_RAMP_EN
  localparam logic [31:0] RAMP_W = 32'(RAMP_DEC);

  logic [31:0] r_cur_period;
  logic [31:0] w_ramp_init;

  // eff<<2 saturates when either of the top two bits would be shifted out
  assign w_ramp_init  = (w_eff_in[31:30] != 2'b00) ? '1 : {w_eff_in[29:0], 2'b00};
  assign w_cur_period = r_cur_period;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_period <= '0;
    end else if (r_state == IDLE && start) begin
      r_cur_period <= w_ramp_init;
    end else if (w_period_end) begin
      // cur >= eff always holds, so the difference cannot underflow
      if ((r_cur_period - r_eff_period) > RAMP_W) begin
        r_cur_period <= r_cur_period - RAMP_W;
      end else begin
        r_cur_period <= r_eff_period;
      end
    end
  end
`else
  assign w_cur_period = r_eff_period;
`endif

  always_comb begin
    w_period_end = (r_state == RUN) && (r_cnt == w_cur_period - 32'd1);
    // stop coinciding with the final wrap still completes the move
    w_last_step  = w_period_end && ((r_step_cnt + 32'd1) == r_step_num);
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (step_num == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (stop) begin
          w_state_next = DONE;
        end else if (r_cnt == SETUP_LAST) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last_step || stop) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_step_num   <= '0;
      r_eff_period <= '0;
      r_cnt        <= '0;
      r_step_cnt   <= '0;
      r_dir        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_step_num   <= step_num;
            r_eff_period <= w_eff_in;
            r_step_cnt   <= '0;
            r_dir        <= dir_in;
            r_cnt        <= '0;
          end
        end
        SETUP: begin
          r_cnt <= (r_cnt == SETUP_LAST) ? '0 : r_cnt + 32'd1;
        end
        RUN: begin
          if (w_period_end) begin
            r_step_cnt <= r_step_cnt + 32'd1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == SETUP) || (r_state == RUN);
  assign done     = (r_state == DONE);
  assign step_out = (r_state == RUN) && (r_cnt < PW_W);
  assign dir_out  = r_dir;
  assign step_cnt = r_step_cnt;

endmodule
